instr_memory_wide: RTL and testbench
====================================

INSTR_MEMORY_WIDE -- requirements
Module: instr_memory_wide

Interface
REQ-001 Parameter WORD_BYTES, default 2: bytes per instruction word, legal 1..4; word width W = 8*WORD_BYTES.
REQ-002 Parameter ADDR_BITS, default 10: word address width; depth 2**ADDR_BITS words.
REQ-003 Parameter BUS_BASE, default 8'h10: control bus base; POS=BASE+0, DATA=BASE+1, STATUS=BASE+2, CKSUM=BASE+3.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 bus_addr  in  8  control bus register address.
REQ-007 bus_read  in  1  bus read strobe, one cycle per access.
REQ-008 bus_write  in  1  bus write strobe, one cycle per access.
REQ-009 bus_data  in  8  bus write data.
REQ-010 bus_rdata  out  8  bus read data, valid with bus_rvalid.
REQ-011 bus_rvalid  out  1  one-cycle pulse, cycle after an accepted bus_read.
REQ-012 read_addr  in  ADDR_BITS  fetch word address.
REQ-013 read_enable  in  1  fetch enable.
REQ-014 read_data  out  W  fetched word, registered.

Function
REQ-015 Loader holds word pointer wptr (ADDR_BITS), byte index bidx (0..WORD_BYTES-1), staging register stg (W-8 bits), 8-bit checksum, flags partial/wrapped.
REQ-016 Loader FSM states: EMPTY (bidx=0) and PARTIAL (bidx>0); EMPTY->PARTIAL on DATA write with WORD_BYTES>1; PARTIAL->EMPTY on last-byte DATA write or any POS write.
REQ-017 Byte order little-endian: byte k of a word lands in bits [8k+7:8k].
REQ-018 DATA write with bidx<WORD_BYTES-1: store byte in stg slot bidx, bidx+1; no RAM write.
REQ-019 DATA write with bidx=WORD_BYTES-1: same cycle write {bus_data, stg} to RAM[wptr], bidx<=0, wptr<=wptr+1.
REQ-020 wptr increments modulo 2**ADDR_BITS; increment from all-ones to 0 sets wrapped (sticky until POS write or reset).
REQ-021 Every DATA write adds bus_data to checksum modulo 256.
REQ-022 POS write: wptr <= {bus_data, zeros} truncated/zero-extended to ADDR_BITS, with bus_data occupying bits starting at bit (ADDR_BITS>=10 ? 2 : 0); partial bytes discarded, bidx<=0, wrapped<=0.
REQ-023 CKSUM write clears checksum to 0 regardless of data; simultaneous DATA write impossible (single bus address).
REQ-024 Writes to other addresses ignored.
REQ-025 bus_read of STATUS returns {4'b0, wrapped, partial, 2'b01}; of CKSUM returns checksum; of POS returns wptr[9:2] (or wptr[7:0] if ADDR_BITS<10); DATA/other addresses return 8'h00; bus_rvalid pulses for every bus_read.
REQ-026 bus_read and bus_write asserted together: write takes effect; read returns pre-write value.
REQ-027 Fetch port: read_enable=1 -> read_data <= RAM[read_addr] next cycle; read_enable=0 -> read_data holds.
REQ-028 Fetch and commit same address same cycle: read_data returns old contents (read-first).
REQ-029 RAM is inferred block RAM, one write port, one read port; contents not reset.

Reset
REQ-030 rst_n low asynchronously forces: wptr=0, bidx=0 (EMPTY), stg=0, checksum=0, wrapped=0, bus_rdata=8'h00, bus_rvalid=0, read_data=0.
REQ-031 Reset mid-word discards staged bytes; no RAM write occurs in that cycle.
REQ-032 First posedge after rst_n rises operates normally.

Verification
REQ-033 Defaults: POS<-8'h01, DATA 8'h34, 8'h12 -> RAM[4]=16'h1234; fetch addr 4 -> read_data=16'h1234 one cycle later.
REQ-034 DATA 8'hAA then POS<-8'h00 then DATA 8'h11, 8'h22 -> RAM[0]=16'h2211; STATUS reads 8'h05 after 8'hAA, 8'h01 after final byte.
REQ-035 ADDR_BITS=10, POS<-8'hFF, write 8 bytes (4 words) -> RAM[1020..1023] loaded, wptr=0, STATUS=8'h09.
REQ-036 Bytes 8'hF0, 8'h20 -> CKSUM reads 8'h10; CKSUM write then read -> 8'h00.
REQ-037 Fetch addr 4 in same cycle as commit to 4 (old 16'h1234, new 16'hBEEF) -> read_data=16'h1234, next fetch 16'hBEEF.
REQ-038 WORD_BYTES=4: DATA 01,02,03,04 -> RAM[wptr]=32'h04030201; rst_n pulsed after 2 bytes -> no write, STATUS=8'h01.

Source files
------------

// File: rtl/instr_memory_wide_if.sv
// Control-bus and fetch-port signal bundle for instr_memory_wide.
// The master side drives strobes, addresses and write data; the slave is the memory.
interface instr_memory_wide_if #(
  parameter int WORD_BYTES = 2,
  parameter int ADDR_BITS  = 10
);
  logic [7:0]              bus_addr;
  logic                    bus_read;
  logic                    bus_write;
  logic [7:0]              bus_data;
  logic [7:0]              bus_rdata;
  logic                    bus_rvalid;
  logic [ADDR_BITS-1:0]    read_addr;
  logic                    read_enable;
  logic [8*WORD_BYTES-1:0] read_data;

  modport master (
    output bus_addr, bus_read, bus_write, bus_data, read_addr, read_enable,
    input  bus_rdata, bus_rvalid, read_data
  );

  modport slave (
    input  bus_addr, bus_read, bus_write, bus_data, read_addr, read_enable,
    output bus_rdata, bus_rvalid, read_data
  );
endinterface

// File: rtl/instr_memory_wide.sv
// Instruction memory with a byte-serial loader on an 8-bit control bus and a
// registered word-wide fetch port; bytes are assembled little-endian into words.
module instr_memory_wide #(
  parameter int         WORD_BYTES = 2,
  parameter int         ADDR_BITS  = 10,
  parameter logic [7:0] BUS_BASE   = 8'h10
) (
  input logic clk,
  input logic rst_n,
  instr_memory_wide_if.slave mem_if
);
  localparam int         W        = 8 * WORD_BYTES;
  localparam int         STG_W    = (WORD_BYTES > 1) ? W - 8 : 8;
  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);
  localparam logic [7:0] A_POS    = BUS_BASE;
  localparam logic [7:0] A_DATA   = BUS_BASE + 8'd1;
  localparam logic [7:0] A_STATUS = BUS_BASE + 8'd2;
  localparam logic [7:0] A_CKSUM  = BUS_BASE + 8'd3;

  typedef enum logic {EMPTY, PARTIAL} ld_state_t;

  ld_state_t            state_q, state_d;
  logic [ADDR_BITS-1:0] wptr;
  logic [1:0]           bidx;
  logic [STG_W-1:0]     stg;
  logic [7:0]           cksum;
  logic                 wrapped;
  logic [W-1:0]         mem [DEPTH];

  logic                 data_wr, pos_wr, ck_wr, commit;
  logic [W-1:0]         commit_word;
  logic [ADDR_BITS-1:0] pos_wptr;
  logic [7:0]           pos_rd;
  logic [7:0]           rd_mux;

  // The POS register exposes the word pointer in 4-word granules on large memories.
  if (ADDR_BITS >= 10) begin : g_pos_wide
    assign pos_wptr = ADDR_BITS'({mem_if.bus_data, 2'b00});
    assign pos_rd   = wptr[9:2];
  end else begin : g_pos_narrow
    assign pos_wptr = ADDR_BITS'(mem_if.bus_data);
    assign pos_rd   = 8'(wptr);
  end

  always_comb begin
    data_wr = mem_if.bus_write && (mem_if.bus_addr == A_DATA);
    pos_wr  = mem_if.bus_write && (mem_if.bus_addr == A_POS);
    ck_wr   = mem_if.bus_write && (mem_if.bus_addr == A_CKSUM);
    commit  = data_wr && (bidx == LAST_IDX);

    commit_word = '0;
    commit_word[W-1 -: 8] = mem_if.bus_data;
    for (int k = 0; k < WORD_BYTES - 1; k++)
      commit_word[8*k +: 8] = stg[8*k +: 8];

    rd_mux = 8'h00;
    case (mem_if.bus_addr)
      A_POS:    rd_mux = pos_rd;
      A_STATUS: rd_mux = {4'b0000, wrapped, state_q == PARTIAL, 2'b01};
      A_CKSUM:  rd_mux = cksum;
      default:  rd_mux = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (data_wr && !commit) state_d = PARTIAL;
      PARTIAL: if (pos_wr || commit)   state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      wptr    <= '0;
      bidx    <= 2'd0;
      stg     <= '0;
      cksum   <= 8'h00;
      wrapped <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pos_wr) begin
        wptr    <= pos_wptr;
        bidx    <= 2'd0;
        wrapped <= 1'b0;
      end else if (commit) begin
        wptr <= wptr + 1'b1;
        bidx <= 2'd0;
        if (&wptr) wrapped <= 1'b1;
      end else if (data_wr) begin
        for (int k = 0; k < WORD_BYTES - 1; k++)
          if (bidx == 2'(k)) stg[8*k +: 8] <= mem_if.bus_data;
        bidx <= bidx + 2'd1;
      end
      if (ck_wr)        cksum <= 8'h00;
      else if (data_wr) cksum <= cksum + mem_if.bus_data;
    end
  end

  // Storage array: single write port, read-first fetch port, contents never reset.
  always_ff @(posedge clk) begin
    if (commit && rst_n) mem[wptr] <= commit_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  mem_if.read_data <= '0;
    else if (mem_if.read_enable) mem_if.read_data <= mem[mem_if.read_addr];
  end

  // Bus read data returns register values sampled before any same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_if.bus_rdata  <= 8'h00;
      mem_if.bus_rvalid <= 1'b0;
    end else begin
      mem_if.bus_rvalid <= mem_if.bus_read;
      if (mem_if.bus_read) mem_if.bus_rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_instr_memory_wide.sv
// Bench for instr_memory_wide: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based loader model.
module tb_instr_memory_wide;
  localparam logic [7:0] POS = 8'h10, DAT = 8'h11, STA = 8'h12, CKS = 8'h13;
  localparam int WB = 2, AB = 10, DEPTH = 1 << AB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  instr_memory_wide_if #(.WORD_BYTES(2), .ADDR_BITS(10)) bi ();
  instr_memory_wide_if #(.WORD_BYTES(4), .ADDR_BITS(8))  b4 ();

  instr_memory_wide #(.WORD_BYTES(2), .ADDR_BITS(10), .BUS_BASE(8'h10))
    u_dut (.clk(clk), .rst_n(rst_n), .mem_if(bi));
  instr_memory_wide #(.WORD_BYTES(4), .ADDR_BITS(8), .BUS_BASE(8'h10))
    u_dut4 (.clk(clk), .rst_n(rst4_n), .mem_if(b4));

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_FE} op_t;
  typedef struct {
    op_t         op;
    logic [9:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bi.bus_write = 1'b0; bi.bus_read = 1'b0; bi.read_enable = 1'b0;
    b4.bus_write = 1'b0; b4.bus_read = 1'b0; b4.read_enable = 1'b0;
  endtask

  task automatic wr(int u, logic [7:0] a, logic [7:0] d);
    if (u == 0) begin bi.bus_addr = a; bi.bus_data = d; bi.bus_write = 1'b1; end
    else        begin b4.bus_addr = a; b4.bus_data = d; b4.bus_write = 1'b1; end
    @(negedge clk);
    idle();
  endtask

  task automatic rd(int u, logic [7:0] a, output logic [7:0] d);
    if (u == 0) begin bi.bus_addr = a; bi.bus_read = 1'b1; end
    else        begin b4.bus_addr = a; b4.bus_read = 1'b1; end
    @(negedge clk);
    idle();
    chk("rvalid", (u == 0) ? 32'(bi.bus_rvalid) : 32'(b4.bus_rvalid), 32'd1);
    d = (u == 0) ? bi.bus_rdata : b4.bus_rdata;
  endtask

  task automatic fe(int u, int a, output logic [31:0] d);
    if (u == 0) begin bi.read_addr = 10'(a); bi.read_enable = 1'b1; end
    else        begin b4.read_addr = 8'(a);  b4.read_enable = 1'b1; end
    @(negedge clk);
    idle();
    d = (u == 0) ? 32'(bi.read_data) : b4.read_data;
  endtask

  task automatic v(op_t op, int a, logic [7:0] d, logic [15:0] e, string nm);
    vec_t t;
    t.op = op; t.addr = 10'(a); t.data = d; t.exp = e; t.name = nm;
    vecs.push_back(t);
  endtask

  // Reference model of the loader: staged bytes live in a queue until a word is full.
  logic [15:0] mem_m [DEPTH];
  bit          known [DEPTH];
  int          known_q[$];
  logic [7:0]  byte_q[$];
  int          m_wptr;
  logic [7:0]  m_ck;
  bit          m_wrapped;

  task automatic m_reset();
    m_wptr = 0; m_ck = 8'h00; m_wrapped = 0; byte_q.delete();
  endtask

  task automatic m_data(logic [7:0] d);
    logic [15:0] word;
    m_ck = m_ck + d;
    byte_q.push_back(d);
    if (byte_q.size() == WB) begin
      word = '0;
      for (int k = 0; k < WB; k++) word = word | (16'(byte_q[k]) << (8 * k));
      mem_m[m_wptr] = word;
      if (!known[m_wptr]) begin known[m_wptr] = 1; known_q.push_back(m_wptr); end
      m_wptr = (m_wptr + 1) % DEPTH;
      if (m_wptr == 0) m_wrapped = 1;
      byte_q.delete();
    end
  endtask

  task automatic m_pos(logic [7:0] d);
    m_wptr = (int'(d) * 4) % DEPTH;
    byte_q.delete();
    m_wrapped = 0;
  endtask

  function automatic logic [7:0] m_status();
    return {4'b0000, m_wrapped, byte_q.size() != 0, 2'b01};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  r8;
    logic [31:0] r32;
    bi.bus_addr = 8'h00; bi.bus_data = 8'h00; bi.read_addr = '0;
    b4.bus_addr = 8'h00; b4.bus_data = 8'h00; b4.read_addr = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset rdata", 32'(bi.bus_rdata), 32'h0);
    chk("reset rvalid", 32'(bi.bus_rvalid), 32'h0);
    chk("reset read_data", 32'(bi.read_data), 32'h0);
    rst_n = 1'b1; rst4_n = 1'b1;
    @(negedge clk);
    rd(0, STA, r8); chk("reset status", 32'(r8), 32'h01);
    rd(0, POS, r8); chk("reset pos", 32'(r8), 32'h00);
    rd(0, CKS, r8); chk("reset cksum", 32'(r8), 32'h00);

    v(OP_WR, POS, 8'h01, 0, "");       v(OP_WR, DAT, 8'h34, 0, "");
    v(OP_WR, DAT, 8'h12, 0, "");       v(OP_FE, 4, 0, 16'h1234, "fetch4");
    v(OP_RD, POS, 0, 16'h01, "pos5");  v(OP_WR, DAT, 8'hAA, 0, "");
    v(OP_RD, STA, 0, 16'h05, "status partial");
    v(OP_WR, POS, 8'h00, 0, "");       v(OP_RD, STA, 0, 16'h01, "status after pos");
    v(OP_WR, DAT, 8'h11, 0, "");       v(OP_WR, DAT, 8'h22, 0, "");
    v(OP_RD, STA, 0, 16'h01, "status word done");
    v(OP_FE, 0, 0, 16'h2211, "fetch0");
    v(OP_RD, CKS, 0, 16'h23, "cksum sum");
    v(OP_WR, CKS, 8'h55, 0, "");       v(OP_RD, CKS, 0, 16'h00, "cksum clear");
    v(OP_WR, DAT, 8'hF0, 0, "");       v(OP_WR, DAT, 8'h20, 0, "");
    v(OP_RD, CKS, 0, 16'h10, "cksum mod256");
    v(OP_WR, POS, 8'hFF, 0, "");
    for (int i = 1; i <= 8; i++) v(OP_WR, DAT, 8'(i), 0, "");
    v(OP_RD, STA, 0, 16'h09, "status wrapped");
    v(OP_RD, POS, 0, 16'h00, "pos wrapped");
    v(OP_FE, 1020, 0, 16'h0201, "fetch1020");
    v(OP_FE, 1023, 0, 16'h0807, "fetch1023");
    v(OP_WR, POS, 8'h00, 0, "");       v(OP_RD, STA, 0, 16'h01, "wrap cleared");
    v(OP_FE, 1, 0, 16'h20F0, "fetch1");
    v(OP_WR, 8'h20, 8'h77, 0, "");     v(OP_RD, 8'h20, 0, 16'h00, "other addr");
    v(OP_RD, DAT, 0, 16'h00, "data read");
    v(OP_RD, STA, 0, 16'h01, "status after ignored");

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR: wr(0, 8'(vecs[i].addr), vecs[i].data);
        OP_RD: begin rd(0, 8'(vecs[i].addr), r8); chk(vecs[i].name, 32'(r8), 32'(vecs[i].exp)); end
        default: begin fe(0, int'(vecs[i].addr), r32); chk(vecs[i].name, r32, 32'(vecs[i].exp)); end
      endcase
    end

    // Fetch and commit to the same word in one cycle: old contents come back.
    wr(0, POS, 8'h01);
    wr(0, DAT, 8'hEF);
    bi.bus_addr = DAT; bi.bus_data = 8'hBE; bi.bus_write = 1'b1;
    bi.read_addr = 10'd4; bi.read_enable = 1'b1;
    @(negedge clk);
    idle();
    chk("read-first old", 32'(bi.read_data), 32'h1234);
    fe(0, 4, r32); chk("read-first new", r32, 32'hBEEF);

    // Simultaneous read and write: read sees the pre-write value.
    bi.bus_addr = POS; bi.bus_data = 8'h40; bi.bus_write = 1'b1; bi.bus_read = 1'b1;
    @(negedge clk);
    idle();
    chk("rw pos old", 32'(bi.bus_rdata), 32'h01);
    rd(0, POS, r8); chk("rw pos new", 32'(r8), 32'h40);
    bi.bus_addr = CKS; bi.bus_data = 8'h00; bi.bus_write = 1'b1; bi.bus_read = 1'b1;
    @(negedge clk);
    idle();
    chk("rw cksum old", 32'(bi.bus_rdata), 32'hE1);
    rd(0, CKS, r8); chk("rw cksum new", 32'(r8), 32'h00);

    // Four-byte words, narrow address, and reset in the middle of a word.
    wr(1, POS, 8'h03);
    for (int i = 1; i <= 4; i++) wr(1, DAT, 8'(i));
    for (int i = 1; i <= 4; i++) wr(1, DAT, 8'(8'h10 + i));
    fe(1, 3, r32); chk("wb4 word3", r32, 32'h04030201);
    fe(1, 4, r32); chk("wb4 word4", r32, 32'h14131211);
    rd(1, POS, r8); chk("wb4 pos", 32'(r8), 32'h05);
    wr(1, POS, 8'h04);
    wr(1, DAT, 8'hAA); wr(1, DAT, 8'hBB); wr(1, DAT, 8'hCC);
    rd(1, STA, r8); chk("wb4 partial", 32'(r8), 32'h05);
    b4.bus_addr = DAT; b4.bus_data = 8'hDD; b4.bus_write = 1'b1;
    rst4_n = 1'b0;
    @(negedge clk);
    idle();
    chk("wb4 reset read_data", b4.read_data, 32'h0);
    chk("wb4 reset rvalid", 32'(b4.bus_rvalid), 32'h0);
    rst4_n = 1'b1;
    @(negedge clk);
    rd(1, STA, r8); chk("wb4 status after reset", 32'(r8), 32'h01);
    rd(1, POS, r8); chk("wb4 pos after reset", 32'(r8), 32'h00);
    rd(1, CKS, r8); chk("wb4 cksum after reset", 32'(r8), 32'h00);
    fe(1, 4, r32); chk("wb4 no write on reset", r32, 32'h14131211);
    for (int i = 1; i <= 4; i++) wr(1, DAT, 8'(i));
    fe(1, 0, r32); chk("wb4 word0", r32, 32'h04030201);

    // Randomized traffic on the two-byte instance against the model.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_reset();
    foreach (known[i]) known[i] = 0;
    known_q.delete();
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      d = 8'($urandom);
      if (r < 45) begin
        wr(0, DAT, d); m_data(d);
      end else if (r < 49) begin
        wr(0, POS, d); m_pos(d);
      end else if (r < 53) begin
        wr(0, CKS, d); m_ck = 8'h00;
      end else if (r < 61) begin
        rd(0, STA, r8); chk("rand status", 32'(r8), 32'(m_status()));
      end else if (r < 69) begin
        rd(0, CKS, r8); chk("rand cksum", 32'(r8), 32'(m_ck));
      end else if (r < 75) begin
        rd(0, POS, r8); chk("rand pos", 32'(r8), 32'((m_wptr >> 2) & 8'hFF));
      end else if (r < 79) begin
        wr(0, 8'h40 + 8'(d[3:0]), d);
        rd(0, 8'h40 + 8'(d[7:4]), r8); chk("rand other", 32'(r8), 32'h0);
      end else if (known_q.size() > 0) begin
        int a;
        a = known_q[$urandom_range(0, known_q.size() - 1)];
        fe(0, a, r32); chk("rand fetch", r32, 32'(mem_m[a]));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
